// File: rtl/stage_rr_arbiter.sv
// stage_rr_arbiter
// Shares one valid/ready processing stage among NUM_REQ requesters. One
// transaction is in flight at a time: accept (IDLE) -> issue to stage (ISSUE)
// -> wait for stage result (WAIT) -> return result to requester (RESP).
// ISSUE and WAIT are each bounded by TIMEOUT cycles; on expiry the transaction
// is dropped and timeout_err pulses for one cycle.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_data/req_ready   requester side, req_ready one-hot in IDLE
//   rsp_valid/rsp_data/rsp_ready   response side, rsp_valid one-hot in RESP
//   stg_valid/stg_data/stg_ready   request channel to the shared stage
//   stg_rsp_valid/stg_rsp_data/stg_rsp_ready  result channel from the stage
//   grant_id                       index of the current/last grant
//   busy                           high whenever not in IDLE
//   timeout_err                    one-cycle pulse when a transaction aborts
module stage_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_W-1:0]             rsp_data,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic                          stg_valid,
   output logic [DATA_W-1:0]             stg_data,
   input  logic                          stg_ready,
   input  logic                          stg_rsp_valid,
   input  logic [DATA_W-1:0]             stg_rsp_data,
   output logic                          stg_rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          timeout_err
);

   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [GW-1:0]       last_grant;
   logic [GW-1:0]       winner_c;
   logic                win_found_c;
   logic [DATA_W-1:0]   data_reg;
   logic [DATA_W-1:0]   rsp_reg;
   logic [CW-1:0]       cnt;
   logic                limit_c;
   logic                accept_c;
   logic                capture_c;
   logic                resp_done_c;
   logic                abort_c;

   // Round-robin search starting one past the last grant. Offsets are
   // scanned from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      int idx;
      winner_c    = '0;
      win_found_c = 1'b0;
      idx         = 0;
      for (int k = int'(NUM_REQ); k >= 1; k--) begin
         idx = int'(last_grant) + k;
         if (idx >= int'(NUM_REQ)) begin
            idx = idx - int'(NUM_REQ);
         end
         if (req_valid[GW'(idx)]) begin
            winner_c    = GW'(idx);
            win_found_c = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and transaction strobes; an exiting handshake beats the limit
   always_comb begin
      state_nxt   = state;
      accept_c    = 1'b0;
      capture_c   = 1'b0;
      resp_done_c = 1'b0;
      abort_c     = 1'b0;
      limit_c     = (cnt == CW'(TIMEOUT - 1));
      case (state)
         S_IDLE: begin
            if (win_found_c) begin
               accept_c  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (stg_ready) begin
               state_nxt = S_WAIT;
            end else if (limit_c) begin
               abort_c   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (stg_rsp_valid) begin
               capture_c = 1'b1;
               state_nxt = S_RESP;
            end else if (limit_c) begin
               abort_c   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_RESP: begin
            if (rsp_ready[grant_id]) begin
               resp_done_c = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Transaction datapath, priority pointer and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_id    <= '0;
         last_grant  <= GW'(NUM_REQ - 1);
         data_reg    <= '0;
         rsp_reg     <= '0;
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= abort_c;
         if (accept_c) begin
            grant_id <= winner_c;
            data_reg <= req_data[int'(winner_c)*int'(DATA_W) +: DATA_W];
         end
         if (capture_c) begin
            rsp_reg <= stg_rsp_data;
         end
         if (abort_c || resp_done_c) begin
            last_grant <= grant_id;
         end
         // Any state change restarts the count, so ISSUE and WAIT each get
         // a fresh TIMEOUT budget.
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (state == S_ISSUE || state == S_WAIT) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Handshake strobes decoded from state
   assign req_ready     = (state == S_IDLE && win_found_c) ? (NUM_REQ'(1) << winner_c) : '0;
   assign rsp_valid     = (state == S_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
   assign rsp_data      = rsp_reg;
   assign stg_valid     = (state == S_ISSUE);
   assign stg_data      = data_reg;
   assign stg_rsp_ready = (state == S_WAIT);
   assign busy          = (state != S_IDLE);

endmodule
